// File: rtl/tri_bus_pkg.sv
// Shared types and pad constants for the tri_bus_port pad bank.
package tri_bus_pkg;

    typedef enum logic [1:0] {ST_RX, ST_DRIVE, ST_TURN} state_t;

    // SB_IO configuration: registered-free tristate output, simple input, pull-up on
    localparam logic [5:0] PIN_TYPE_TRI = 6'b101001;
    localparam logic       PULLUP_EN    = 1'b1;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_pad_bit.sv
// One bidirectional pad cell; purely combinational, all timing lives in the fabric.
module io_pad_bit (
    input  logic out,
    output logic in,
    input  logic en,
    inout  wire  pin
);

    assign pin = en ? out : 1'bz;
    assign in  = pin;

endmodule

// File: rtl/tri_bus_port.sv
// Bidirectional pad bank with registered drive path, input synchroniser and
// a dead-time turnaround before received data is declared valid.
module tri_bus_port #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               TURN_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drive_req,
    input  logic [WIDTH-1:0] dout,
    output logic             drive_ack,
    output logic [WIDTH-1:0] din,
    output logic             din_valid,
    output logic [WIDTH-1:0] din_rise,
    output logic [WIDTH-1:0] din_fall,
    inout  wire  [WIDTH-1:0] pin
);
    import tri_bus_pkg::*;

    localparam int            CW       = cnt_w(TURN_CYCLES + SYNC_STAGES);
    localparam logic [CW-1:0] CNT_INIT = CW'(TURN_CYCLES + SYNC_STAGES - 1);

    state_t                              state, nxt;
    logic [CW-1:0]                       cnt, cnt_nxt;
    logic                                oe;
    logic [WIDTH-1:0]                    dq;
    logic [WIDTH-1:0]                    pin_in;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync;
    logic [WIDTH-1:0]                    prev;
    logic                                valid_q;
    logic                                v2;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_pad
            io_pad_bit u_pad (
                .out (dq[i]),
                .in  (pin_in[i]),
                .en  (oe),
                .pin (pin[i])
            );
        end
    endgenerate

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            ST_RX:    if (drive_req) nxt = ST_DRIVE;
            ST_DRIVE: if (!drive_req) begin
                          nxt     = ST_TURN;
                          cnt_nxt = CNT_INIT;
                      end
            // Re-driving during turnaround is safe: we were the last driver
            ST_TURN:  if (drive_req)      nxt = ST_DRIVE;
                      else if (cnt == '0) nxt = ST_RX;
                      else                cnt_nxt = cnt - CW'(1);
            default: begin
                nxt     = ST_TURN;
                cnt_nxt = CNT_INIT;
            end
        endcase
    end

    // oe is one flop so reset releases every pin through its async clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_TURN;
            cnt     <= CNT_INIT;
            oe      <= 1'b0;
            dq      <= '0;
            sync    <= {SYNC_STAGES{RESET_VAL}};
            prev    <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            oe      <= (nxt == ST_DRIVE);
            if (nxt == ST_DRIVE) dq <= dout;
            sync[0] <= pin_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
            prev    <= din;
            valid_q <= din_valid;
        end
    end

    assign drive_ack = oe;
    assign din       = sync[SYNC_STAGES-1];
    assign din_valid = (state == ST_RX);
    // Strobes need two valid cycles and are dropped when we are about to leave RX
    assign v2        = din_valid & valid_q & ~drive_req;
    assign din_rise  = {WIDTH{v2}} & ~prev & din;
    assign din_fall  = {WIDTH{v2}} & prev & ~din;

endmodule
